pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
// Per-frame game sequencer for the VGA Pong datapath. Advances ball and
// paddle positions once per video frame in 20x20-pixel grid-cell units. Runs
// wall, paddle and miss detection, plus score, lives and the serve/over flow.
// Feeds ball_x/ball_y/paddle_y straight into the top-level pixel compare logic.
// PARAMETERS
// GRID_W      32  playfield width in cells (640/20)
// GRID_H      24  playfield height in cells (480/20)
// PADDLE_X     3  fixed paddle column (cells)
// PADDLE_LEN   5  paddle height in cells
// PADDLE_Y0   10  paddle row after reset / new game
// SERVE_X     16  ball column at serve
// SERVE_Y     12  ball row at serve
// BALL_DIV     2  frames per ball step (>=1)
// PAD_DIV      1  frames per paddle step (>=1)
// LIVES        3  misses allowed per game (1..7)
// PORTS
// clk        in   1  pixel clock domain (25 MHz)
// rst_n      in   1  synchronous active-low reset
// frame_tick in   1  1-cycle pulse per frame (start of vblank); spacing >=2 clk
// btn_up     in   1  paddle up, already synchronised level
// btn_down   in   1  paddle down, already synchronised level
// ball_x     out  clog2(GRID_W)  ball column
// ball_y     out  clog2(GRID_H)  ball row
// paddle_y   out  clog2(GRID_H)  paddle top row
// score      out  8  paddle hits this game, saturates at 255
// lives      out  3  remaining lives
// game_over  out  1  high while in OVER
// state      out  2  00 SERVE, 01 PLAY, 10 MISS, 11 OVER
// BEHAVIOUR
// - All registers update on posedge clk. rst_n=0 overrides everything on that edge.
// - Reset values: ball=(SERVE_X,SERVE_Y), dx=+1, dy=+1, paddle_y=PADDLE_Y0,
//   score=0, lives=LIVES, game_over=0, state=SERVE, both frame dividers=0.
// - Inputs are sampled only on cycles with frame_tick=1. Outputs change 1 clk later.
// - Paddle: pad_div counts ticks 0..PAD_DIV-1. On wrap: btn_up && paddle_y>0 -> -1;
//   else btn_down && paddle_y<GRID_H-PADDLE_LEN -> +1. Up wins when both pressed.
//   The paddle moves in SERVE and PLAY and is frozen in MISS and OVER.
// - SERVE: ball held at serve cell, ball_div held at 0. A tick with either button
//   pressed -> PLAY.
// - PLAY: ball_div counts ticks 0..BALL_DIV-1. Each wrap is one step, evaluated on
//   the pre-step position in this order:
//   y: dy=-1 && y==0 or dy=+1 && y==GRID_H-1 -> flip dy; y moves 1 in new dy.
//   x: dx=+1 && x==GRID_W-1 -> flip dx, x-=1.
//      hit = dx=-1 && x==PADDLE_X+1 && paddle_y<=y<=paddle_y+PADDLE_LEN-1
//      (pre-step y). On hit: dx=+1, x+=1, score+=1 (saturating).
//      dx=-1 && x==0 -> MISS; the ball is not moved.
//      Otherwise x moves 1 in dx. Corner cases apply the x and y flips together.
// - MISS (exactly 1 clk): lives-=1. If the result is 0 -> OVER, otherwise
//   ball=serve cell, dx=+1, dy=+1, ball_div=0 -> SERVE.
// - OVER: game_over=1, ball frozen. A tick with any button pressed -> score=0,
//   lives=LIVES, paddle_y=PADDLE_Y0, ball=serve cell, dx=dy=+1 -> SERVE.
// - Positions never leave 0..GRID_W-1 and 0..GRID_H-1.
// - Reset asserted mid-game returns all outputs to reset values on the next edge.
// TESTING
// 1 rst_n=0 for 2 clk -> ball(16,12), paddle_y=10, score=0, lives=3, state=SERVE.
// 2 BALL_DIV=1. Tick with btn_down, then release -> PLAY, paddle_y=11.
//   After 11 more ticks y=23; next tick y=22 with dy=-1.
// 3 paddle_y=8, ball reaches x=4 with dx=-1, y=10 -> next step x=5, dx=+1,
//   score=1.
// 4 paddle_y=0, ball arrives at y=15 moving left -> passes x=3, reaches x=0;
//   next step MISS, then lives=2, ball(16,12), state=SERVE.
// 5 Three misses -> state=OVER, game_over=1. Tick with btn_up -> score=0,
//   lives=3, SERVE.
// 6 Hold btn_up 12 ticks from paddle_y=10 -> stops at 0. Both buttons -> moves up.
//   rst_n=0 during PLAY -> reset values next edge.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame Pong sequencer for ball, paddle, score, lives and the serve/play/miss/over flow.
// Latency: a frame tick is acted on at that clock edge, so outputs change one clk after the tick; MISS lasts exactly 1 clk.
// Backpressure: none; the block free-runs on i_frame_tick and its outputs feed the pixel compare logic directly.
//
// Ports:
//   i_clk, i_rst_n      pixel clock, synchronous active-low reset
//   i_frame_tick        1-cycle pulse per frame; buttons are only looked at on these cycles
//   i_btn_up/i_btn_down synchronised paddle buttons (up wins when both are pressed)
//   o_ball_x/o_ball_y   ball cell;  o_paddle_y  paddle top row
//   o_score             paddle hits this game (saturating);  o_lives  remaining lives
//   o_game_over         high in OVER;  o_state  00 SERVE, 01 PLAY, 10 MISS, 11 OVER
module pong_game_ctrl #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 24,
    parameter int PADDLE_X   = 3,
    parameter int PADDLE_LEN = 5,
    parameter int PADDLE_Y0  = 10,
    parameter int SERVE_X    = 16,
    parameter int SERVE_Y    = 12,
    parameter int BALL_DIV   = 2,
    parameter int PAD_DIV    = 1,
    parameter int LIVES      = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_frame_tick,
    input  logic                      i_btn_up,
    input  logic                      i_btn_down,
    output logic [$clog2(GRID_W)-1:0] o_ball_x,
    output logic [$clog2(GRID_H)-1:0] o_ball_y,
    output logic [$clog2(GRID_H)-1:0] o_paddle_y,
    output logic [7:0]                o_score,
    output logic [2:0]                o_lives,
    output logic                      o_game_over,
    output logic [1:0]                o_state
);
    localparam int XW  = $clog2(GRID_W);
    localparam int YW  = $clog2(GRID_H);
    localparam int BDW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
    localparam int PDW = (PAD_DIV > 1) ? $clog2(PAD_DIV) : 1;

    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [YW-1:0] PAD_MAX = YW'(GRID_H - PADDLE_LEN);
    localparam logic [XW-1:0] HIT_X   = XW'(PADDLE_X + 1);

    typedef enum logic [1:0] {
        S_SERVE = 2'b00,
        S_PLAY  = 2'b01,
        S_MISS  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t         r_state;
    logic [XW-1:0]  r_ball_x;
    logic [YW-1:0]  r_ball_y;
    logic           r_dx_pos;      // 1: moving right (+1), 0: moving left (-1)
    logic           r_dy_pos;      // 1: moving down (+1), 0: moving up (-1)
    logic [YW-1:0]  r_paddle_y;
    logic [7:0]     r_score;
    logic [2:0]     r_lives;
    logic           r_game_over;
    logic [BDW-1:0] r_ball_div;
    logic [PDW-1:0] r_pad_div;

    logic           w_pad_wrap;
    logic           w_ball_wrap;
    logic [YW-1:0]  w_pad_next;
    logic           w_dy_flip;
    logic           w_dy_next;
    logic [YW-1:0]  w_y_next;
    logic           w_x_wall;
    logic           w_hit;
    logic           w_miss;
    logic [XW-1:0]  w_x_next;
    logic           w_dx_next;
    logic [7:0]     w_score_inc;
    logic [2:0]     w_lives_dec;

    assign w_pad_wrap  = (r_pad_div == PDW'(PAD_DIV - 1));
    assign w_ball_wrap = (r_ball_div == BDW'(BALL_DIV - 1));

    always_comb begin
        w_pad_next = r_paddle_y;
        if (i_btn_up && (r_paddle_y != '0)) begin
            w_pad_next = r_paddle_y - YW'(1);
        end else if (i_btn_down && (r_paddle_y < PAD_MAX)) begin
            w_pad_next = r_paddle_y + YW'(1);
        end
    end

    // Vertical bounce: flip first, then move one row in the new direction.
    assign w_dy_flip = r_dy_pos ? (r_ball_y == Y_MAX) : (r_ball_y == '0);
    assign w_dy_next = r_dy_pos ^ w_dy_flip;
    assign w_y_next  = w_dy_next ? (r_ball_y + YW'(1)) : (r_ball_y - YW'(1));

    // Paddle hit uses the pre-step ball row against the current paddle span.
    assign w_x_wall = r_dx_pos && (r_ball_x == X_MAX);
    assign w_hit    = !r_dx_pos && (r_ball_x == HIT_X) &&
                      (r_ball_y >= r_paddle_y) &&
                      ({1'b0, r_ball_y} <= ({1'b0, r_paddle_y} + (YW+1)'(PADDLE_LEN - 1)));
    assign w_miss   = !r_dx_pos && (r_ball_x == '0);

    always_comb begin
        w_x_next  = r_ball_x;
        w_dx_next = r_dx_pos;
        if (w_x_wall) begin
            w_x_next  = r_ball_x - XW'(1);
            w_dx_next = 1'b0;
        end else if (w_hit) begin
            w_x_next  = r_ball_x + XW'(1);
            w_dx_next = 1'b1;
        end else if (!w_miss) begin
            w_x_next  = r_dx_pos ? (r_ball_x + XW'(1)) : (r_ball_x - XW'(1));
        end
    end

    assign w_score_inc = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);
    assign w_lives_dec = r_lives - 3'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_SERVE;
            r_ball_x    <= XW'(SERVE_X);
            r_ball_y    <= YW'(SERVE_Y);
            r_dx_pos    <= 1'b1;
            r_dy_pos    <= 1'b1;
            r_paddle_y  <= YW'(PADDLE_Y0);
            r_score     <= 8'd0;
            r_lives     <= 3'(LIVES);
            r_game_over <= 1'b0;
            r_ball_div  <= '0;
            r_pad_div   <= '0;
        end else begin
            // Paddle runs on its own divider while the ball is live or waiting to serve.
            if (i_frame_tick && ((r_state == S_SERVE) || (r_state == S_PLAY))) begin
                if (w_pad_wrap) begin
                    r_pad_div  <= '0;
                    r_paddle_y <= w_pad_next;
                end else begin
                    r_pad_div  <= r_pad_div + PDW'(1);
                end
            end

            case (r_state)
                S_SERVE: begin
                    if (i_frame_tick) begin
                        r_ball_div <= '0;
                        if (i_btn_up || i_btn_down) begin
                            r_state <= S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (i_frame_tick) begin
                        if (w_ball_wrap) begin
                            r_ball_div <= '0;
                            if (w_miss) begin
                                // Ball stays where it left the field.
                                r_state <= S_MISS;
                            end else begin
                                r_ball_x <= w_x_next;
                                r_dx_pos <= w_dx_next;
                                r_ball_y <= w_y_next;
                                r_dy_pos <= w_dy_next;
                                if (w_hit) begin
                                    r_score <= w_score_inc;
                                end
                            end
                        end else begin
                            r_ball_div <= r_ball_div + BDW'(1);
                        end
                    end
                end
                S_MISS: begin
                    r_lives <= w_lives_dec;
                    if (w_lives_dec == 3'd0) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_ball_x   <= XW'(SERVE_X);
                        r_ball_y   <= YW'(SERVE_Y);
                        r_dx_pos   <= 1'b1;
                        r_dy_pos   <= 1'b1;
                        r_ball_div <= '0;
                        r_state    <= S_SERVE;
                    end
                end
                S_OVER: begin
                    if (i_frame_tick && (i_btn_up || i_btn_down)) begin
                        r_score     <= 8'd0;
                        r_lives     <= 3'(LIVES);
                        r_paddle_y  <= YW'(PADDLE_Y0);
                        r_ball_x    <= XW'(SERVE_X);
                        r_ball_y    <= YW'(SERVE_Y);
                        r_dx_pos    <= 1'b1;
                        r_dy_pos    <= 1'b1;
                        r_game_over <= 1'b0;
                        r_state     <= S_SERVE;
                    end
                end
                default: r_state <= S_SERVE;
            endcase
        end
    end

    assign o_ball_x    = r_ball_x;
    assign o_ball_y    = r_ball_y;
    assign o_paddle_y  = r_paddle_y;
    assign o_score     = r_score;
    assign o_lives     = r_lives;
    assign o_game_over = r_game_over;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: bench for pong_game_ctrl with a one-step-per-frame ball.
// Latency: each driven clock pushes the expected outputs, popped and compared 1 time unit after that edge.
// Backpressure: none; stimulus is frame ticks with an idle clock between them.
module tb_pong_game_ctrl;
    localparam int GW = 32, GH = 24, PX = 3, PL = 5, PY0 = 10, SX = 16, SY = 12;
    localparam int BALL_DIV = 1, PAD_DIV = 1, LIVES = 3;
    localparam int ST_SERVE = 0, ST_PLAY = 1, ST_MISS = 2, ST_OVER = 3;

    logic       clk, rst_n, tick, up, dn;
    logic [4:0] ball_x, ball_y, paddle_y;
    logic [7:0] score;
    logic [2:0] lives;
    logic       game_over;
    logic [1:0] state;

    pong_game_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .PADDLE_X(PX), .PADDLE_LEN(PL), .PADDLE_Y0(PY0),
        .SERVE_X(SX), .SERVE_Y(SY), .BALL_DIV(BALL_DIV), .PAD_DIV(PAD_DIV), .LIVES(LIVES)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_btn_up(up), .i_btn_down(dn),
        .o_ball_x(ball_x), .o_ball_y(ball_y), .o_paddle_y(paddle_y), .o_score(score),
        .o_lives(lives), .o_game_over(game_over), .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] x; logic [4:0] y; logic [4:0] py;
        logic [7:0] sc; logic [2:0] lv; logic go; logic [1:0] st;
    } exp_t;

    typedef struct {
        logic rst_n; logic up; logic dn;
        int x; int y; int py; int st; int lv; int sc;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference game state, kept as signed integers with +1/-1 directions.
    int m_x, m_y, m_dx, m_dy, m_py, m_score, m_lives, m_state, m_go, m_bdiv, m_pdiv;

    task automatic model_reset();
        m_x = SX; m_y = SY; m_dx = 1; m_dy = 1; m_py = PY0;
        m_score = 0; m_lives = LIVES; m_go = 0; m_state = ST_SERVE; m_bdiv = 0; m_pdiv = 0;
    endtask

    task automatic ball_step();
        int ny, ndy, nx, ndx;
        ndy = m_dy;
        if ((m_dy < 0 && m_y == 0) || (m_dy > 0 && m_y == GH - 1)) ndy = -m_dy;
        ny = m_y + ndy;
        ndx = m_dx;
        nx = m_x;
        if (m_dx > 0 && m_x == GW - 1) begin
            ndx = -1; nx = m_x - 1;
        end else if (m_dx < 0 && m_x == PX + 1 && m_y >= m_py && m_y <= m_py + PL - 1) begin
            ndx = 1; nx = m_x + 1;
            m_score = (m_score < 255) ? m_score + 1 : 255;
        end else if (m_dx < 0 && m_x == 0) begin
            m_state = ST_MISS;
            return;
        end else begin
            nx = m_x + m_dx;
        end
        m_x = nx; m_dx = ndx; m_y = ny; m_dy = ndy;
    endtask

    task automatic model_clk(input logic r, input logic t, input logic u, input logic d);
        int npy;
        if (!r) begin
            model_reset();
            return;
        end
        if (m_state == ST_MISS) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) begin
                m_state = ST_OVER; m_go = 1;
            end else begin
                m_x = SX; m_y = SY; m_dx = 1; m_dy = 1; m_bdiv = 0; m_state = ST_SERVE;
            end
            return;
        end
        if (!t) return;
        npy = m_py;
        if (m_state == ST_SERVE || m_state == ST_PLAY) begin
            m_pdiv = m_pdiv + 1;
            if (m_pdiv == PAD_DIV) begin
                m_pdiv = 0;
                if (u && m_py > 0) npy = m_py - 1;
                else if (d && m_py < GH - PL) npy = m_py + 1;
            end
        end
        case (m_state)
            ST_SERVE: begin
                m_bdiv = 0;
                if (u || d) m_state = ST_PLAY;
            end
            ST_PLAY: begin
                m_bdiv = m_bdiv + 1;
                if (m_bdiv == BALL_DIV) begin
                    m_bdiv = 0;
                    ball_step();
                end
            end
            ST_OVER: begin
                if (u || d) begin
                    m_score = 0; m_lives = LIVES; npy = PY0;
                    m_x = SX; m_y = SY; m_dx = 1; m_dy = 1; m_go = 0; m_state = ST_SERVE;
                end
            end
            default: ;
        endcase
        m_py = npy;
    endtask

    task automatic check_sb();
        exp_t e, a;
        e = sb_q.pop_front();
        a.x = ball_x; a.y = ball_y; a.py = paddle_y; a.sc = score;
        a.lv = lives; a.go = game_over; a.st = state;
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard cyc %0d: got x=%0d y=%0d py=%0d sc=%0d lv=%0d go=%0d st=%0d, want x=%0d y=%0d py=%0d sc=%0d lv=%0d go=%0d st=%0d",
                     cyc, a.x, a.y, a.py, a.sc, a.lv, a.go, a.st, e.x, e.y, e.py, e.sc, e.lv, e.go, e.st);
        end
    endtask

    task automatic clk_cycle(input logic r, input logic t, input logic u, input logic d);
        exp_t e;
        @(negedge clk);
        rst_n = r; tick = t; up = u; dn = d;
        model_clk(r, t, u, d);
        e.x = 5'(m_x); e.y = 5'(m_y); e.py = 5'(m_py); e.sc = 8'(m_score);
        e.lv = 3'(m_lives); e.go = 1'(m_go); e.st = 2'(m_state);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        check_sb();
    endtask

    task automatic do_tick(input logic u, input logic d);
        clk_cycle(1'b1, 1'b1, u, d);
    endtask

    // Buttons wiggle on non-tick cycles; they must be ignored there.
    task automatic do_idle();
        clk_cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        vec_t v;
        rst_n = 1'b0; tick = 1'b0; up = 1'b0; dn = 1'b0;
        model_reset();

        // Reset, a tick without buttons (stays in SERVE), launch with down, then 12 steps.
        vt.push_back('{1'b0, 1'b0, 1'b0, 16, 12, 10, ST_SERVE, 3, 0});
        vt.push_back('{1'b0, 1'b0, 1'b0, 16, 12, 10, ST_SERVE, 3, 0});
        vt.push_back('{1'b1, 1'b0, 1'b0, 16, 12, 10, ST_SERVE, 3, 0});
        vt.push_back('{1'b1, 1'b0, 1'b1, 16, 12, 11, ST_PLAY, 3, 0});
        for (int n = 1; n <= 12; n++)
            vt.push_back('{1'b1, 1'b0, 1'b0, 16 + n, (n <= 11) ? 12 + n : 34 - n, 11, ST_PLAY, 3, 0});

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            if (!v.rst_n) clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            else          do_tick(v.up, v.dn);
            chk($sformatf("row%0d_x", i), 32'(ball_x), v.x);
            chk($sformatf("row%0d_y", i), 32'(ball_y), v.y);
            chk($sformatf("row%0d_py", i), 32'(paddle_y), v.py);
            chk($sformatf("row%0d_state", i), 32'(state), v.st);
            chk($sformatf("row%0d_lives", i), 32'(lives), v.lv);
            chk($sformatf("row%0d_score", i), 32'(score), v.sc);
            if (v.rst_n) do_idle();
        end

        // Paddle to row 8, ball comes back left along a known path and is returned.
        for (int n = 13; n <= 44; n++) begin
            do_tick(n <= 15, 1'b0);
            if (n == 42) begin
                chk("pre_hit_x", 32'(ball_x), 4);
                chk("pre_hit_y", 32'(ball_y), 8);
                chk("pre_hit_py", 32'(paddle_y), 8);
            end
            if (n == 43) begin
                chk("hit_x", 32'(ball_x), 5);
                chk("hit_y", 32'(ball_y), 9);
                chk("hit_score", 32'(score), 1);
            end
            if (n == 44) chk("after_hit_x", 32'(ball_x), 6);
            do_idle();
        end

        // Reset in the middle of PLAY.
        clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_state", 32'(state), ST_SERVE);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_x", 32'(ball_x), 16);
        chk("midrst_py", 32'(paddle_y), 10);

        // Three rallies with the paddle parked at the top: each ends in a miss.
        for (int r = 0; r < 3; r++) begin
            do_tick(1'b1, 1'b0);
            chk($sformatf("serve%0d_state", r), 32'(state), ST_PLAY);
            do_idle();
            for (int n = 1; n <= 47; n++) begin
                do_tick(1'b1, 1'b0);
                if (n == 46) begin
                    chk($sformatf("r%0d_edge_x", r), 32'(ball_x), 0);
                    chk($sformatf("r%0d_edge_y", r), 32'(ball_y), 12);
                    chk($sformatf("r%0d_py_top", r), 32'(paddle_y), 0);
                end
                if (n == 47) begin
                    chk($sformatf("r%0d_miss_state", r), 32'(state), ST_MISS);
                    chk($sformatf("r%0d_miss_x", r), 32'(ball_x), 0);
                end
                do_idle();
                if (n == 47) begin
                    chk($sformatf("r%0d_lives", r), 32'(lives), 2 - r);
                    chk($sformatf("r%0d_post_state", r), 32'(state), (r == 2) ? ST_OVER : ST_SERVE);
                    chk($sformatf("r%0d_game_over", r), 32'(game_over), (r == 2) ? 1 : 0);
                    if (r < 2) chk($sformatf("r%0d_serve_x", r), 32'(ball_x), 16);
                end
            end
        end

        // OVER holds without a button, restarts with one.
        do_tick(1'b0, 1'b0);
        chk("over_hold_state", 32'(state), ST_OVER);
        chk("over_hold_y", 32'(ball_y), 12);
        do_idle();
        do_tick(1'b1, 1'b0);
        chk("restart_state", 32'(state), ST_SERVE);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_py", 32'(paddle_y), 10);
        chk("restart_go", 32'(game_over), 0);
        chk("restart_x", 32'(ball_x), 16);
        do_idle();

        // Both buttons: up wins. Then run down into the bottom limit.
        do_tick(1'b1, 1'b1);
        chk("both_py", 32'(paddle_y), 9);
        chk("both_state", 32'(state), ST_PLAY);
        do_idle();
        for (int n = 0; n < 12; n++) begin
            do_tick(1'b0, 1'b1);
            do_idle();
        end
        chk("bottom_py", 32'(paddle_y), 19);
        do_tick(1'b1, 1'b1);
        chk("both_play_py", 32'(paddle_y), 18);
        do_idle();

        clk_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_rst_py", 32'(paddle_y), 10);
        chk("final_rst_y", 32'(ball_y), 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
